// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: loader FSM state type and system mode encodings shared by the arbiter and its bench
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_e;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_EXEC = 3'd2;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: execute-stage request/response plus the single data-BRAM port
// master: the arbiter (drives stall/rdata/rvalid and the BRAM address/data/write enable)
// slave:  the environment (execute stage requests, BRAM returns registered read data)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 15
);
  logic ex_req, ex_we, ex_stall, ex_rvalid, bram_we;
  logic [31:0] ex_addr, ex_wdata, ex_rdata, bram_din, bram_dout;
  logic [ADDR_W-1:0] bram_addr;
  modport master (
    input  ex_req, ex_we, ex_addr, ex_wdata, bram_dout,
    output ex_stall, ex_rdata, ex_rvalid, bram_addr, bram_din, bram_we
  );
  modport slave (
    output ex_req, ex_we, ex_addr, ex_wdata, bram_dout,
    input  ex_stall, ex_rdata, ex_rvalid, bram_addr, bram_din, bram_we
  );
endinterface

// File: rtl/mem_port_arbiter_byte_packer.sv
// byte_packer: assembles four strobed bytes, first byte as MSB, into a 32-bit word
// Ports: clk, rst (async active-high); clr restarts the word; en/din accept one byte;
//        word/word_valid present the completed word in the cycle its 4th byte arrives.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0] cnt_q, cnt_d;
  logic [23:0] sh_q, sh_d;
  always_comb begin
    cnt_d = clr ? 2'd0 : en ? cnt_q + 2'd1 : cnt_q;
    sh_d = clr ? 24'd0 : en ? {sh_q[15:0], din} : sh_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      sh_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
    end
  assign word = {sh_q, din};
  assign word_valid = en && cnt_q == 2'd3;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the data-BRAM port between the UART program loader and the execute stage
// Ports: clk, rst (async active-high); mode (1 load, 2 exec); rx_data/rx_valid UART bytes;
//        bus (master) carries execute request/stall/read data and the BRAM port;
//        load_done pulse, sticky load_err, load_sum byte checksum.
// Build option MEM_ARB_CHECKSUM_EN: accumulate load_sum; otherwise load_sum is tied to 0.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         mode,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  mem_port_arbiter_if.master bus,
  output logic               load_done,
  output logic               load_err,
  output logic [7:0]         load_sum
);
  state_e state_q, state_d;
  logic [31:0] n_q, n_d, wcnt_q, wcnt_d, din_q, din_d, word;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d, done_q, done_d, err_q, err_d, rvalid_q, rvalid_d;
  logic load, active, en, word_valid, hdr_end, last, owns;
  logic unused_addr_bits;
  assign load = mode == MODE_LOAD;
  assign active = state_q == HDR || state_q == DATA;
  assign en = active && load && rx_valid;
  assign hdr_end = state_q == HDR && word_valid;
  assign last = state_q == DATA && word_valid && wcnt_q == n_q - 32'd1;
  assign unused_addr_bits = ^{bus.ex_addr[31:ADDR_W+2], bus.ex_addr[1:0]};
  byte_packer u_packer (
    .clk(clk), .rst(rst), .clr(!active), .en(en), .din(rx_data),
    .word(word), .word_valid(word_valid)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = load ? HDR : IDLE;
      HDR:  state_d = !load ? IDLE : !word_valid ? HDR : word == 32'd0 ? DONE : DATA;
      DATA: state_d = !load ? IDLE : last ? DONE : DATA;
      DONE: state_d = load ? DONE : IDLE;
    endcase
  end
  // Words past the BRAM depth are counted (so the load still completes) but never written.
  always_comb begin
    n_d = hdr_end ? word : n_q;
    wcnt_d = hdr_end ? 32'd0 : state_q == DATA && word_valid ? wcnt_q + 32'd1 : wcnt_q;
    we_d = state_q == DATA && word_valid && (wcnt_q >> ADDR_W) == 32'd0;
    addr_d = we_d ? wcnt_q[ADDR_W-1:0] : addr_q;
    din_d = we_d ? word : din_q;
    done_d = (hdr_end && word == 32'd0) || last;
    err_d = state_q == IDLE && load ? 1'b0
          : (active && !load) || (hdr_end && word != 32'd0 && ((word - 32'd1) >> ADDR_W) != 32'd0) ? 1'b1
          : err_q;
    rvalid_d = bus.ex_req && !bus.ex_we && !owns;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      n_q <= '0;
      wcnt_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      n_q <= n_d;
      wcnt_q <= wcnt_d;
      addr_q <= addr_d;
      din_q <= din_d;
      we_q <= we_d;
      done_q <= done_d;
      err_q <= err_d;
      rvalid_q <= rvalid_d;
    end
  // The loader keeps the port through the load_done cycle so its final registered write lands first.
  always_comb begin
    owns = active || done_q;
    bus.ex_stall = bus.ex_req && owns;
    bus.bram_addr = owns ? addr_q : bus.ex_addr[ADDR_W+1:2];
    bus.bram_din = owns ? din_q : bus.ex_wdata;
    bus.bram_we = owns ? we_q : bus.ex_req && bus.ex_we;
  end
  assign bus.ex_rdata = bus.bram_dout;
  assign bus.ex_rvalid = rvalid_q;
  assign load_done = done_q;
  assign load_err = err_q;
`ifdef MEM_ARB_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  always_comb sum_d = state_q == IDLE && load ? 8'd0 : en ? sum_q + rx_data : sum_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sum_q <= '0;
    else sum_q <= sum_d;
  assign load_sum = sum_q;
`else
  assign load_sum = 8'd0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench for two arbiters (deep and 4-word BRAM) against a byte-queue loader model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic clk = 0, rst = 0;
  logic [2:0] mode = 0;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0, ex_req = 0, ex_we = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0;
  logic done0, done1, err0, err1;
  logic [7:0] sum0, sum1;
  int checks = 0, errors = 0;
  mem_port_arbiter_if #(.ADDR_W(15)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(2)) b1 ();
  assign b0.ex_req = ex_req;
  assign b0.ex_we = ex_we;
  assign b0.ex_addr = ex_addr;
  assign b0.ex_wdata = ex_wdata;
  assign b1.ex_req = ex_req;
  assign b1.ex_we = ex_we;
  assign b1.ex_addr = ex_addr;
  assign b1.ex_wdata = ex_wdata;
  mem_port_arbiter #(.ADDR_W(15)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .rx_data(rx_data), .rx_valid(rx_valid),
    .bus(b0.master), .load_done(done0), .load_err(err0), .load_sum(sum0)
  );
  mem_port_arbiter #(.ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .rx_data(rx_data), .rx_valid(rx_valid),
    .bus(b1.master), .load_done(done1), .load_err(err1), .load_sum(sum1)
  );
  always #5 clk = ~clk;
  logic [31:0] bmem0 [32768];
  logic [31:0] bmem1 [4];
  always @(posedge clk) begin
    if (b0.bram_we) bmem0[b0.bram_addr] <= b0.bram_din;
    b0.bram_dout <= bmem0[b0.bram_addr];
    if (b1.bram_we) bmem1[b1.bram_addr] <= b1.bram_din;
    b1.bram_dout <= bmem1[b1.bram_addr];
  end

  // reference model: phase 0 idle, 1 header, 2 data, 3 done
  int ph;
  logic [7:0] q [$];
  logic [7:0] stream [$];
  longint n, got;
  logic pw [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];
  logic err_e [2];
  logic rv_k [2];
  logic [31:0] rv_d [2];
  logic done_e, rv_e;
  logic [7:0] sum_e;
  logic [31:0] em0 [int];
  logic [31:0] em1 [int];

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got_v, exp_v, $time);
    end
  endtask

  function automatic longint depth(input int i);
    return i != 0 ? 64'd4 : 64'd32768;
  endfunction

  function automatic int widx(input int i, input logic [31:0] a);
    return i != 0 ? int'(a[3:2]) : int'(a[16:2]);
  endfunction

  task automatic mem_wr(input int i, input int a, input logic [31:0] d);
    if (i != 0) em1[a] = d;
    else em0[a] = d;
  endtask

  task automatic model_reset();
    ph = 0;
    q.delete();
    pw = '{1'b0, 1'b0};
    err_e = '{1'b0, 1'b0};
    done_e = 0;
    rv_e = 0;
    sum_e = 0;
  endtask

  task automatic model_step();
    logic own, rd;
    logic [31:0] w;
    int a;
    own = ph == 1 || ph == 2 || done_e;
    rd = ex_req && !ex_we && !own;
    for (int i = 0; i < 2; i++) begin
      a = widx(i, ex_addr);
      if (rd) begin
        rv_k[i] = i != 0 ? em1.exists(a) != 0 : em0.exists(a) != 0;
        rv_d[i] = !rv_k[i] ? 32'd0 : i != 0 ? em1[a] : em0[a];
      end
      if (own && pw[i]) mem_wr(i, int'(pa[i]), pd[i]);
      if (!own && ex_req && ex_we) mem_wr(i, a, ex_wdata);
      pw[i] = 0;
    end
    rv_e = rd;
    done_e = 0;
    if (ph == 0) begin
      if (mode == MODE_LOAD) begin
        ph = 1;
        q.delete();
        err_e = '{1'b0, 1'b0};
        sum_e = 0;
      end
    end else if (ph == 3) begin
      if (mode != MODE_LOAD) ph = 0;
    end else if (mode != MODE_LOAD) begin
      ph = 0;
      err_e = '{1'b1, 1'b1};
    end else if (rx_valid) begin
      sum_e += rx_data;
      q.push_back(rx_data);
      if (q.size() == 4) begin
        w = {q[0], q[1], q[2], q[3]};
        q.delete();
        if (ph == 1) begin
          n = longint'(w);
          got = 0;
          ph = n == 0 ? 3 : 2;
          done_e = n == 0;
          for (int i = 0; i < 2; i++) if (n > depth(i)) err_e[i] = 1;
        end else begin
          for (int i = 0; i < 2; i++)
            if (got < depth(i)) begin
              pw[i] = 1;
              pa[i] = 32'(got);
              pd[i] = w;
            end
          got++;
          if (got == n) begin
            done_e = 1;
            ph = 3;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic own, we;
    logic [31:0] ea, sum_x;
    own = ph == 1 || ph == 2 || done_e;
`ifdef MEM_ARB_CHECKSUM_EN
    sum_x = 32'(sum_e);
`else
    sum_x = 32'd0;
`endif
    for (int i = 0; i < 2; i++) begin
      we = own ? pw[i] : ex_req && ex_we;
      ea = own ? pa[i] : 32'(widx(i, ex_addr));
      check($sformatf("ex_stall%0d", i), i != 0 ? b1.ex_stall : b0.ex_stall, 32'(ex_req && own));
      check($sformatf("bram_we%0d", i), i != 0 ? b1.bram_we : b0.bram_we, 32'(we));
      if (we) begin
        check($sformatf("bram_addr%0d", i), i != 0 ? 32'(b1.bram_addr) : 32'(b0.bram_addr), ea);
        check($sformatf("bram_din%0d", i), i != 0 ? b1.bram_din : b0.bram_din, own ? pd[i] : ex_wdata);
      end
      check($sformatf("load_done%0d", i), i != 0 ? done1 : done0, 32'(done_e));
      check($sformatf("load_err%0d", i), i != 0 ? err1 : err0, 32'(err_e[i]));
      check($sformatf("load_sum%0d", i), i != 0 ? 32'(sum1) : 32'(sum0), sum_x);
      check($sformatf("ex_rvalid%0d", i), i != 0 ? b1.ex_rvalid : b0.ex_rvalid, 32'(rv_e));
      if (rv_e && rv_k[i])
        check($sformatf("ex_rdata%0d", i), i != 0 ? b1.ex_rdata : b0.ex_rdata, rv_d[i]);
    end
  endtask

  task automatic cyc(input logic [2:0] m, input logic rv, input logic [7:0] b,
                     input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mode = m;
    rx_valid = rv;
    rx_data = b;
    ex_req = rq;
    ex_we = w;
    ex_addr = a;
    ex_wdata = d;
    #1 compare_all();
    @(posedge clk);
    if (!rst) model_step();
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(3) << 17) | ($urandom_range(7) << 2) | $urandom_range(3);
  endfunction

  task automatic rcyc(input logic [2:0] m, input logic rv, input logic [7:0] b);
    cyc(m, rv, b, 1'($urandom_range(1)), $urandom_range(3) == 0, rand_addr(), $urandom());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    rx_valid = 0;
    ex_req = 0;
    model_reset();
    #1 compare_all();
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic set_stream(input int words);
    stream.delete();
    for (int s = 24; s >= 0; s -= 8) stream.push_back(8'(words >> s));
    for (int k = 0; k < 4 * words; k++) stream.push_back(8'($urandom()));
  endtask

  task automatic run_stream(input int abort_at, input int rst_at);
    logic stopped = 0;
    rcyc(MODE_LOAD, 0, 8'd0);
    for (int k = 0; k < stream.size() && !stopped; k++) begin
      if (k == abort_at) stopped = 1;
      else if (k == rst_at) begin
        do_reset();
        stopped = 1;
      end else begin
        while ($urandom_range(2) == 0) rcyc(MODE_LOAD, 0, 8'd0);
        rcyc(MODE_LOAD, 1, stream[k]);
      end
    end
    if (!stopped) repeat (3) rcyc(MODE_LOAD, 1'($urandom_range(1)), 8'($urandom()));
    for (int w = 0; w < 8; w++) cyc(MODE_EXEC, 1'($urandom_range(1)), 8'($urandom()), 1, 0, 32'(w << 2), 0);
    repeat (4) rcyc(MODE_EXEC, 1'($urandom_range(1)), 8'($urandom()));
  endtask

  initial begin
    model_reset();
    #2 rst = 1;
    repeat (2) begin
      @(negedge clk);
      #1 compare_all();
    end
    @(posedge clk);
    #1 rst = 0;
    stream = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    run_stream(-1, -1);
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_stream(-1, -1);
    cyc(MODE_EXEC, 0, 8'd0, 1, 1, 32'h8, 32'h12345678);
    cyc(MODE_EXEC, 0, 8'd0, 1, 0, 32'h8, 32'd0);
    cyc(MODE_EXEC, 0, 8'd0, 0, 0, 32'd0, 32'd0);
    set_stream(3);
    run_stream(10, -1);
    set_stream(5);
    run_stream(-1, -1);
    for (int t = 0; t < 14; t++) begin
      set_stream(int'($urandom_range(6)));
      run_stream($urandom_range(3) == 0 ? int'($urandom_range(stream.size())) : -1, t == 7 ? 6 : -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
